// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register file's single write port between the ALU
//             result path and the memory-load path. Each requester uses a
//             valid/ready handshake. One requester wins per cycle. MEM wins
//             ties until the ALU has waited MAX_WAIT cycles. Writes to $0 are
//             accepted but suppressed. The write port is driven from flops,
//             so there is exactly one cycle of latency.
//  Ports    : clk, rst (async, active-high)
//             alu_valid/alu_reg/alu_data -> alu_ready (comb)
//             mem_valid/mem_reg/mem_data -> mem_ready (comb)
//             write_register, write_data, RegWrite, grant_src (registered)
//             alu_starved (wait counter >= MAX_WAIT)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              RegWrite,
  output logic              grant_src,
  output logic              alu_starved
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);
  localparam logic [3:0] C_CNT_SAT  = 4'hF;

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              reg_write_q, reg_write_d;
  logic              grant_src_q, grant_src_d;

  logic              starved;
  logic              alu_gnt;
  logic              mem_gnt;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  assign starved = (wait_cnt_q >= C_MAX_WAIT);

  // Grants double as the ready outputs. Gating with rst keeps both readies
  // low for the whole reset window, so no handshake can complete then.
  always_comb begin
    alu_gnt = !rst && alu_valid && (!mem_valid || starved);
    mem_gnt = !rst && mem_valid && (!alu_valid || !starved);
  end

  always_comb begin
    sel_reg  = mem_gnt ? mem_reg  : alu_reg;
    sel_data = mem_gnt ? mem_data : alu_data;
  end

  // Next-state logic for the write port and the ALU wait counter.
  always_comb begin
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    reg_write_d      = 1'b0;
    grant_src_d      = grant_src_q;
    wait_cnt_d       = wait_cnt_q;

    if (alu_gnt || mem_gnt) begin
      grant_src_d = mem_gnt;
      // A $0 destination completes the handshake but leaves the port idle
      // and the address/data lines at their previous values.
      if (sel_reg != '0) begin
        reg_write_d      = 1'b1;
        write_register_d = sel_reg;
        write_data_d     = sel_data;
      end
    end

    if (!alu_valid || alu_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != C_CNT_SAT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_register_q <= '0;
      write_data_q     <= '0;
      reg_write_q      <= 1'b0;
      grant_src_q      <= 1'b0;
      wait_cnt_q       <= 4'd0;
    end else begin
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      reg_write_q      <= reg_write_d;
      grant_src_q      <= grant_src_d;
      wait_cnt_q       <= wait_cnt_d;
    end
  end

  assign alu_ready      = alu_gnt;
  assign mem_ready      = mem_gnt;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign RegWrite       = reg_write_q;
  assign grant_src      = grant_src_q;
  assign alu_starved    = starved;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed, table-driven bench for regfile_wb_arbiter. It also
//             keeps a small register-file model that is fed by the write port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        RegWrite;
  logic        grant_src;
  logic        alu_starved;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [32];

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .write_register(write_register), .write_data(write_data), .RegWrite(RegWrite),
    .grant_src(grant_src), .alu_starved(alu_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model; $0 is hardwired to zero.
  always @(posedge clk) begin
    if (RegWrite && write_register != 5'd0) rf[write_register] <= write_data;
  end

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        e_ar;
    logic        e_mr;
    logic        e_st;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_gs;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md,
                              input logic e_ar, input logic e_mr, input logic e_st,
                              input logic e_rw, input logic [4:0] e_wr, input logic [31:0] e_wd,
                              input logic e_gs);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_st = e_st;
    v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd; v.e_gs = e_gs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    // Sequential table: each row is one cycle, and the wait counter carries
    // over from row to row.
    //            av ar     ad            mv mr    md            ar mr st  rw wr     wd            gs
    vecs[0]  = mk(1, 5'd19, 32'h63636363, 0, 5'd0, 32'h0,        1, 0, 0,  1, 5'd19, 32'h63636363, 0);
    vecs[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 0,  0, 5'd19, 32'h63636363, 0);
    vecs[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 0,  0, 5'd19, 32'h63636363, 0);
    vecs[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 0,  0, 5'd19, 32'h63636363, 0);
    vecs[4]  = mk(1, 5'd26, 32'h11111111, 1, 5'd9, 32'h22222222, 0, 1, 0,  1, 5'd9,  32'h22222222, 1);
    vecs[5]  = mk(1, 5'd26, 32'h11111111, 1, 5'd9, 32'h22222222, 0, 1, 0,  1, 5'd9,  32'h22222222, 1);
    vecs[6]  = mk(1, 5'd26, 32'h11111111, 1, 5'd9, 32'h22222222, 0, 1, 0,  1, 5'd9,  32'h22222222, 1);
    vecs[7]  = mk(1, 5'd26, 32'h11111111, 1, 5'd9, 32'h22222222, 0, 1, 0,  1, 5'd9,  32'h22222222, 1);
    vecs[8]  = mk(1, 5'd26, 32'h11111111, 1, 5'd9, 32'h22222222, 1, 0, 1,  1, 5'd26, 32'h11111111, 0);
    vecs[9]  = mk(1, 5'd26, 32'h11111111, 1, 5'd9, 32'h22222222, 0, 1, 0,  1, 5'd9,  32'h22222222, 1);
    vecs[10] = mk(0, 5'd0,  32'h0,        1, 5'd0, 32'h77777777, 0, 1, 0,  0, 5'd9,  32'h22222222, 1);
    vecs[11] = mk(1, 5'd30, 32'hAAAA0000, 1, 5'd30, 32'h5555FFFF, 0, 1, 0, 1, 5'd30, 32'h5555FFFF, 1);
    vecs[12] = mk(1, 5'd30, 32'hAAAA0000, 0, 5'd0, 32'h0,        1, 0, 0,  1, 5'd30, 32'hAAAA0000, 0);
    vecs[13] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 0, 0,  0, 5'd30, 32'hAAAA0000, 0);

    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    check("reset RegWrite", 32'(RegWrite), 32'd0);
    check("reset write_register", 32'(write_register), 32'd0);
    check("reset write_data", write_data, 32'd0);
    check("reset grant_src", 32'(grant_src), 32'd0);
    check("reset alu_starved", 32'(alu_starved), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
      #2;
      check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
      check($sformatf("v%0d alu_starved", i), 32'(alu_starved), 32'(vecs[i].e_st));
      @(posedge clk);
      #1;
      check($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(vecs[i].e_rw));
      check($sformatf("v%0d write_register", i), 32'(write_register), 32'(vecs[i].e_wr));
      check($sformatf("v%0d write_data", i), write_data, vecs[i].e_wd);
      check($sformatf("v%0d grant_src", i), 32'(grant_src), 32'(vecs[i].e_gs));
    end

    // Register file contents after the sequence.
    check("rf[19]", rf[19], 32'h63636363);
    check("rf[9]", rf[9], 32'h22222222);
    check("rf[26]", rf[26], 32'h11111111);
    check("rf[30] last grant", rf[30], 32'hAAAA0000);
    check("rf[0]", rf[0], 32'h0);

    // Asynchronous reset in the middle of a cycle while the ALU keeps
    // requesting; everything must drop at once, without waiting for an edge.
    drive(1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    check("pre-rst RegWrite", 32'(RegWrite), 32'd1);
    check("pre-rst write_register", 32'(write_register), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("async rst RegWrite", 32'(RegWrite), 32'd0);
    check("async rst write_register", 32'(write_register), 32'd0);
    check("async rst write_data", write_data, 32'd0);
    check("async rst alu_ready", 32'(alu_ready), 32'd0);
    check("async rst mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clk);
    #1;
    check("in rst RegWrite", 32'(RegWrite), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("post-rst alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk);
    #1;
    check("post-rst RegWrite", 32'(RegWrite), 32'd1);
    check("post-rst write_register", 32'(write_register), 32'd5);
    check("post-rst write_data", write_data, 32'h12345678);
    check("post-rst grant_src", 32'(grant_src), 32'd0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    check("post-rst idle RegWrite", 32'(RegWrite), 32'd0);
    check("rf[5]", rf[5], 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
